// File: rtl/tbd_accel_pkg.sv
// Shared constants and types for the accelerator's windowing front end.
package tbd_accel_pkg;

  localparam int unsigned PixW     = 8;
  localparam int unsigned DimW     = 16;
  localparam int unsigned MaxWidth = 1024;

  typedef logic [PixW-1:0] pixel_t;
  typedef logic [DimW-1:0] coord_t;

  // Element k = row*3 + col; row 0 is the oldest line, col 0 the leftmost.
  typedef pixel_t [8:0] window_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } win_state_e;

endpackage

// File: rtl/tbd_window_gen_if.sv
// Pixel-in / window-out streaming handshakes of the window generator.
interface tbd_window_gen_if;
  import tbd_accel_pkg::*;

  logic    px_valid;
  logic    px_ready;
  pixel_t  px_data;
  logic    win_valid;
  logic    win_ready;
  window_t win;
  coord_t  win_x;
  coord_t  win_y;

  modport master (
    output px_valid, px_data, win_ready,
    input  px_ready, win_valid, win, win_x, win_y
  );

  modport slave (
    input  px_valid, px_data, win_ready,
    output px_ready, win_valid, win, win_x, win_y
  );
endinterface

// File: rtl/tbd_line_buf.sv
// Line buffer: combinational read and synchronous write at one shared address.
module tbd_line_buf #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Contents are always written in the current frame before being read.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/tbd_window_gen.sv
// Streaming 3x3 neighbourhood generator: buffers two prior rows and emits one
// window per interior pixel with its centre coordinates.
module tbd_window_gen
  import tbd_accel_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = MaxWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  coord_t              width_i,
  input  coord_t              height_i,
  tbd_window_gen_if.slave     bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                cfg_err_o
);

  localparam int unsigned AddrW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned LbW   = 2 * PixW;

  win_state_e state_q, state_d;
  coord_t     c_q, c_d, r_q, r_d;
  coord_t     w_m1_q, w_m1_d, h_m1_q, h_m1_d;
  window_t    work_q, work_d, work_shift;
  window_t    out_win_q, out_win_d;
  coord_t     out_x_q, out_x_d, out_y_q, out_y_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

  logic           px_ready, accept, load, cfg_ok;
  logic [LbW-1:0] lb_rdata, lb_wdata;
  pixel_t         lb_a, lb_b;

  // Single buffer stores {row r-2, row r-1} per column.
  assign {lb_b, lb_a} = lb_rdata;
  assign lb_wdata     = {lb_a, bus.px_data};

  tbd_line_buf #(.DEPTH(MAX_WIDTH), .WIDTH(LbW)) u_line_buf (
    .clk_i   (clk_i),
    .we_i    (accept),
    .addr_i  (AddrW'(c_q)),
    .wdata_i (lb_wdata),
    .rdata_o (lb_rdata)
  );

  assign px_ready = (state_q == RUN) && (!out_valid_q || bus.win_ready);
  assign accept   = bus.px_valid && px_ready;
  assign cfg_ok   = (width_i >= coord_t'(3)) && (width_i <= coord_t'(MAX_WIDTH)) &&
                    (height_i >= coord_t'(3));

  // Working window shifted left with the new column {B[c], A[c], p}.
  always_comb begin
    for (int row = 0; row < 3; row++) begin
      work_shift[row*3]     = work_q[row*3+1];
      work_shift[row*3 + 1] = work_q[row*3+2];
    end
    work_shift[2] = lb_b;
    work_shift[5] = lb_a;
    work_shift[8] = bus.px_data;
  end

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    r_d         = r_q;
    w_m1_d      = w_m1_q;
    h_m1_d      = h_m1_q;
    work_d      = work_q;
    out_win_d   = out_win_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    cfg_err_d   = 1'b0;
    done_d      = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            state_d = RUN;
            w_m1_d  = width_i - coord_t'(1);
            h_m1_d  = height_i - coord_t'(1);
            c_d     = '0;
            r_d     = '0;
          end else begin
            cfg_err_d = 1'b1;
            done_d    = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          work_d = work_shift;
          load   = (c_q >= coord_t'(2)) && (r_q >= coord_t'(2));
          if (c_q == w_m1_q) begin
            c_d = '0;
            r_d = r_q + coord_t'(1);
            if (r_q == h_m1_q) state_d = FLUSH;
          end else begin
            c_d = c_q + coord_t'(1);
          end
        end
      end
      FLUSH: begin
        if (!out_valid_q || bus.win_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Output register: a fresh load wins over a same-edge consume.
    if (load) begin
      out_valid_d = 1'b1;
      out_win_d   = work_shift;
      out_x_d     = c_q - coord_t'(1);
      out_y_d     = r_q - coord_t'(1);
    end else if (bus.win_ready) begin
      out_valid_d = 1'b0;
    end

    busy_d = (state_d == RUN) || (state_d == FLUSH);
    done_d = done_d || (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      c_q         <= '0;
      r_q         <= '0;
      w_m1_q      <= '0;
      h_m1_q      <= '0;
      work_q      <= '0;
      out_win_q   <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      r_q         <= r_d;
      w_m1_q      <= w_m1_d;
      h_m1_q      <= h_m1_d;
      work_q      <= work_d;
      out_win_q   <= out_win_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.px_ready  = px_ready;
  assign bus.win_valid = out_valid_q;
  assign bus.win       = out_win_q;
  assign bus.win_x     = out_x_q;
  assign bus.win_y     = out_y_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_tbd_window_gen.sv
// Directed bench for tbd_window_gen: golden 3x3 windows from a stored frame.
module tb_tbd_window_gen;
  import tbd_accel_pkg::*;

  localparam int unsigned MW = 1024;

  typedef struct packed {
    window_t win;
    coord_t  x;
    coord_t  y;
  } obs_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   start = 1'b0;
  coord_t width = '0;
  coord_t height = '0;
  logic   busy, done, cfg_err;

  int     errors = 0;
  int     checks = 0;
  int     done_cnt = 0;
  obs_t   obs_q[$];
  pixel_t pix [0:4095];

  always #5 clk = ~clk;

  tbd_window_gen_if bus ();

  tbd_window_gen #(.MAX_WIDTH(MW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .width_i   (width),
    .height_i  (height),
    .bus       (bus),
    .busy_o    (busy),
    .done_o    (done),
    .cfg_err_o (cfg_err)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic window_t mkw(input pixel_t a, b, c, d, e, f, g, h, i);
    return {i, h, g, f, e, d, c, b, a};
  endfunction

  function automatic window_t gold(input int w, input int x, input int y);
    window_t g;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        g[r*3+c] = pix[(y - 1 + r) * w + (x - 1 + c)];
    return g;
  endfunction

  // Stream monitor: collects accepted windows and checks handshake rules.
  logic stall_q = 1'b0;
  logic done_prev = 1'b0;
  obs_t held;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q) begin
        chk("hold_valid", bus.win_valid, 1'b1);
        chk("hold_data", {bus.win, bus.win_x, bus.win_y}, held);
      end
      if (bus.win_valid && !bus.win_ready) chk("px_ready_blocked", bus.px_ready, 1'b0);
      if (bus.win_valid && bus.win_ready) obs_q.push_back({bus.win, bus.win_x, bus.win_y});
      if (done) begin
        done_cnt++;
        chk("done_busy", busy, 1'b0);
        chk("done_single", done_prev, 1'b0);
      end
      stall_q   = bus.win_valid && !bus.win_ready;
      held      = {bus.win, bus.win_x, bus.win_y};
      done_prev = done;
    end else begin
      stall_q   = 1'b0;
      done_prev = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1.
  task automatic do_start(input int w, input int h);
    start  = 1'b1;
    width  = coord_t'(w);
    height = coord_t'(h);
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // mode 0: always valid/ready; mode 1: random valid, ready 1-of-3 cycles.
  task automatic run_frame(input int w, input int h, input int mode, input int npix,
                           input bit mid_start);
    int idx = 0;
    int cyc = 0;
    int budget = w * h * 10 + 100;
    bit acc;
    bit finished = 1'b0;
    do_start(w, h);
    while (!finished && cyc < budget) begin
      bus.win_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (idx < npix) begin
        bus.px_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.px_data  = pix[idx];
      end else begin
        bus.px_valid = 1'b0;
      end
      start = mid_start && (cyc == 6);
      if (start) begin
        width  = coord_t'(5);
        height = coord_t'(5);
      end
      @(negedge clk);
      acc = bus.px_valid && bus.px_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
      finished = (idx >= npix) && ((npix < w * h) || (done_cnt > 0));
    end
    chk("frame_timeout", finished, 1'b1);
    start         = 1'b0;
    bus.px_valid  = 1'b0;
    bus.win_ready = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int w, input int h);
    int k = 0;
    chk({tag, "_count"}, obs_q.size(), (w - 2) * (h - 2));
    for (int y = 1; y <= h - 2; y++)
      for (int x = 1; x <= w - 2; x++) begin
        if (k < obs_q.size()) begin
          chk({tag, "_win"}, obs_q[k].win, gold(w, x, y));
          chk({tag, "_xy"}, {obs_q[k].x, obs_q[k].y}, {coord_t'(x), coord_t'(y)});
        end
        k++;
      end
  endtask

  task automatic settle_and_check_done(input string tag, input int exp_done);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, done_cnt, exp_done);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    bus.px_valid  = 1'b0;
    bus.px_data   = '0;
    bus.win_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_win_valid", bus.win_valid, 1'b0);
    chk("rst_px_ready", bus.px_ready, 1'b0);
    chk("rst_win", {bus.win, bus.win_x, bus.win_y}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4x4 ramp, always ready
    for (int i = 0; i < 16; i++) pix[i] = pixel_t'(i);
    obs_q.delete(); done_cnt = 0;
    run_frame(4, 4, 0, 16, 1'b0);
    check_frame("ramp", 4, 4);
    if (obs_q.size() == 4) begin
      chk("ramp_w11", obs_q[0].win, mkw(0, 1, 2, 4, 5, 6, 8, 9, 10));
      chk("ramp_w21", obs_q[1].win, mkw(1, 2, 3, 5, 6, 7, 9, 10, 11));
      chk("ramp_w12", obs_q[2].win, mkw(4, 5, 6, 8, 9, 10, 12, 13, 14));
      chk("ramp_w22", obs_q[3].win, mkw(5, 6, 7, 9, 10, 11, 13, 14, 15));
    end
    settle_and_check_done("ramp", 1);

    // Same frame with backpressure and bursty input
    obs_q.delete(); done_cnt = 0;
    run_frame(4, 4, 1, 16, 1'b0);
    check_frame("stall", 4, 4);
    settle_and_check_done("stall", 1);

    // Rejected configurations
    obs_q.delete(); done_cnt = 0;
    do_start(2, 4);
    @(negedge clk);
    chk("w2_cfg_err", cfg_err, 1'b1);
    chk("w2_done", done, 1'b1);
    chk("w2_busy", busy, 1'b0);
    chk("w2_px_ready", bus.px_ready, 1'b0);
    @(negedge clk);
    chk("w2_cfg_err_clr", cfg_err, 1'b0);
    chk("w2_done_clr", done, 1'b0);
    chk("w2_px_ready2", bus.px_ready, 1'b0);
    @(posedge clk); #1;
    do_start(MW + 1, 3);
    @(negedge clk);
    chk("wmax_cfg_err", cfg_err, 1'b1);
    chk("wmax_done", done, 1'b1);
    chk("wmax_busy", busy, 1'b0);
    chk("wmax_px_ready", bus.px_ready, 1'b0);
    @(negedge clk);
    chk("wmax_cfg_err_clr", cfg_err, 1'b0);
    chk("wmax_busy2", busy, 1'b0);
    @(posedge clk); #1;
    chk("cfg_no_windows", obs_q.size(), 0);

    // start_i during a frame is ignored
    for (int i = 0; i < 16; i++) pix[i] = pixel_t'($urandom_range(0, 255));
    obs_q.delete(); done_cnt = 0;
    run_frame(4, 4, 1, 16, 1'b1);
    check_frame("midstart", 4, 4);
    settle_and_check_done("midstart", 1);

    // Maximum width, three rows, random data
    for (int i = 0; i < MW * 3; i++) pix[i] = pixel_t'($urandom_range(0, 255));
    obs_q.delete(); done_cnt = 0;
    run_frame(MW, 3, 0, MW * 3, 1'b0);
    check_frame("maxw", MW, 3);
    settle_and_check_done("maxw", 1);

    // Reset after 10 pixels of a 5x5 frame, then a clean frame
    for (int i = 0; i < 25; i++) pix[i] = pixel_t'($urandom_range(0, 255));
    obs_q.delete(); done_cnt = 0;
    run_frame(5, 5, 0, 10, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_win_valid", bus.win_valid, 1'b0);
    chk("abort_px_ready", bus.px_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    settle_and_check_done("abort", 0);
    for (int i = 0; i < 25; i++) pix[i] = pixel_t'($urandom_range(0, 255));
    obs_q.delete(); done_cnt = 0;
    run_frame(5, 5, 1, 25, 1'b0);
    check_frame("after_rst", 5, 5);
    settle_and_check_done("after_rst", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tbd_window_gen.md
Name: tbd_window_gen

Overview:
Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel edge kernel in the user-domain accelerator. Consumes a raster-order 8-bit pixel stream from the accelerator's memory-read path. Buffers the two previous image rows internally. Emits one full 3x3 window per interior pixel, with its centre coordinates, so the kernel sees real neighbours instead of a replicated single pixel.

Parameters:
MAX_WIDTH, 1024, maximum supported image width in pixels (line-buffer depth)
PIX_W, 8, pixel width in bits
DIM_W, 16, width of dimension and coordinate fields

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  single-cycle frame start; samples width_i/height_i
width_i  in  DIM_W  image width in pixels
height_i  in  DIM_W  image height in pixels
px_valid_i  in  1  input pixel valid
px_ready_o  out  1  input pixel ready
px_data_i  in  PIX_W  input pixel, raster order
win_valid_o  out  1  window valid
win_ready_i  in  1  window accepted by downstream
win_o  out  9*PIX_W  window; element k=row*3+col at bits [k*PIX_W +: PIX_W]; row 0 = oldest line, col 0 = leftmost
win_x_o  out  DIM_W  centre x of current window
win_y_o  out  DIM_W  centre y of current window
busy_o  out  1  frame in progress
done_o  out  1  single-cycle pulse at end of frame
cfg_err_o  out  1  single-cycle pulse; start rejected

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Line-buffer contents are not reset; they are never observed before being written in the current frame.
- FSM states and transitions:
  - IDLE -> RUN on start_i with valid config.
  - RUN -> FLUSH when the last pixel (x=W-1, y=H-1) is accepted.
  - FLUSH -> DONE when the output register is empty or is being consumed.
  - DONE -> IDLE after one cycle; done_o=1 and busy_o=0 in DONE.
- Config check at start_i in IDLE:
  - Valid: 3 <= width_i <= MAX_WIDTH and height_i >= 3. W and H are latched.
  - Invalid: stay IDLE; cfg_err_o and done_o pulse together on the next cycle; no windows are emitted.
  - start_i outside IDLE is ignored.
- busy_o = 1 in RUN and FLUSH.
- Input acceptance: px_ready_o = (state==RUN) && (!win_valid_o || win_ready_i). A pixel is accepted when px_valid_i && px_ready_o.
- On accepting pixel p at column c, row r:
  - Read column c of both line buffers: A holds row r-1, B holds row r-2.
  - Shift the window left by one column; the new right column is {B[c], A[c], p} (top to bottom).
  - Write B[c] <= A[c] and A[c] <= p.
  - Advance c; at c=W-1, wrap c to 0 and increment r.
- Window emission: when the accepted pixel has r>=2 and c>=2, load the output register on that edge. win_valid_o rises the next cycle with win_x_o=c-1 and win_y_o=r-1. Latency is 1 cycle from the completing accept.
- Pixels with r<2 or c<2 update the buffers but emit nothing. At column wrap the window contents are stale; they are never emitted, because c<2 gates emission.
- Output handshake:
  - win_o, win_x_o and win_y_o are held stable while win_valid_o && !win_ready_i.
  - win_valid_o clears on win_ready_i unless a new window loads on the same edge; back-to-back throughput is 1 window/cycle.
- Window count per frame is exactly (W-2)*(H-2). Coordinates range over x in 1..W-2 and y in 1..H-2.
- Width rules: all additions are DIM_W wide; the c and r comparisons use latched W-1 and H-1.
- Reset mid-frame returns to IDLE immediately, drops any pending window and produces no done_o. The next start_i begins a clean frame.

Decomposition:
- tbd_accel_pkg holds:
  - PixW, DimW and MaxWidth constants.
  - pixel_t and coord_t typedefs.
  - window_t, a packed array [9] of pixel_t.
  - The win_state_e enum (IDLE, RUN, FLUSH, DONE).
- One sub-module, tbd_line_buf: a MAX_WIDTH x PIX_W register array with a combinational read port and a synchronous write port at the same address. It is instantiated twice (A and B), or once at 2*PIX_W wide.

Test Plan:
- 4x4 frame, pixel value = 4y+x, win_ready_i=1 -> 4 windows:
  - (1,1) = {0,1,2,4,5,6,8,9,10}
  - (2,1) = {1,2,3,5,6,7,9,10,11}
  - (1,2) and (2,2) correct
  - then a single done_o pulse, busy_o=0.
- Same frame with win_ready_i toggled 1-of-3 cycles, random px_valid_i -> identical window sequence; win_o stable while stalled; px_ready_o=0 whenever the output is full and not consumed.
- width_i=2 or width_i=MAX_WIDTH+1 -> cfg_err_o and done_o pulse one cycle after start_i; busy_o stays 0; px_ready_o stays 0.
- MAX_WIDTH x 3 frame of random data -> MAX_WIDTH-2 windows matching the golden model; no address wrap errors.
- start_i asserted mid-frame -> ignored; output identical to the undisturbed frame.
- rst_ni asserted after 10 pixels of a 5x5 frame, then a new 5x5 frame -> 9 correct windows with no stale data from the aborted frame.
